// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the multi-cycle chunked adder.
//   state_t    - sequencer states (IDLE, RUN, DONE)
//   DEF_WIDTH  - default operand/sum width
//   DEF_CHUNK  - default bits added per cycle
//   idx_width  - chunk index width, clog2 with a 1-bit floor
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_CHUNK = 8;

   function automatic int unsigned idx_width(input int unsigned nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/chunked_adder_chunk.sv
// full_adder / chunk_adder: combinational CHUNK-bit ripple-carry slice used
// once per cycle by chunked_adder.
//   full_adder  : a, b, c_in -> sum, c_out (1 bit)
//   chunk_adder : a[CHUNK], b[CHUNK], c_in -> sum[CHUNK], c_out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module chunk_adder #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] sum,
   output logic             c_out
);

   logic [CHUNK:0] carry;

   assign carry[0] = c_in;
   assign c_out    = carry[CHUNK];

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .a     (a[i]),
         .b     (b[i]),
         .c_in  (carry[i]),
         .sum   (sum[i]),
         .c_out (carry[i+1])
      );
   end

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: WIDTH-bit adder that processes CHUNK bits per clock.
// An operation is accepted in IDLE, summed chunk by chunk (LSB first) in RUN
// and held in DONE until the consumer takes it.
//   clk, rst_n          - clock, async active-low reset
//   in_valid / in_ready - operand handshake (a, b, c_in)
//   out_valid/out_ready - result handshake (sum, c_out)
module chunked_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   if (WIDTH % CHUNK != 0) begin : g_width_check
      $error("chunked_adder: WIDTH must be a multiple of CHUNK");
   end

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDXW   = idx_width(NCHUNK);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_t            state;
   logic [IDXW-1:0]   idx;
   logic              carry;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;

   int unsigned       lsb;
   logic [CHUNK-1:0]  a_chunk;
   logic [CHUNK-1:0]  b_chunk;
   logic [CHUNK-1:0]  chunk_sum;
   logic              chunk_carry;

   always_comb begin
      lsb     = 32'(idx) * CHUNK;
      a_chunk = a_q[lsb +: CHUNK];
      b_chunk = b_q[lsb +: CHUNK];
   end

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a     (a_chunk),
      .b     (b_chunk),
      .c_in  (carry),
      .sum   (chunk_sum),
      .c_out (chunk_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum       <= '0;
         c_out     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  carry    <= c_in;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               sum[lsb +: CHUNK] <= chunk_sum;
               carry             <= chunk_carry;
               idx               <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  c_out     <= chunk_carry;
                  out_valid <= 1'b1;
                  idx       <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed self-checking bench for chunked_adder.
// Instantiates a WIDTH=32/CHUNK=8 adder and a single-chunk (CHUNK=32) adder.
module tb_chunked_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        c_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] sum;
   logic        c_out;

   logic        w_in_valid = 1'b0;
   logic        w_in_ready;
   logic [31:0] w_a = '0;
   logic [31:0] w_b = '0;
   logic        w_c_in = 1'b0;
   logic        w_out_valid;
   logic        w_out_ready = 1'b0;
   logic [31:0] w_sum;
   logic        w_c_out;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   chunked_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out)
   );

   chunked_adder #(.WIDTH(32), .CHUNK(32)) dut_wide (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready),
      .a         (w_a),
      .b         (w_b),
      .c_in      (w_c_in),
      .out_valid (w_out_valid),
      .out_ready (w_out_ready),
      .sum       (w_sum),
      .c_out     (w_c_out)
   );

   // Drive one operation into dut; returns #1 after the accepting edge.
   task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic cv);
      @(negedge clk);
      a = av; b = bv; c_in = cv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges until dut out_valid is seen (bounded at 20).
   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests_run++;
      if (sum !== 32'h0) begin tests_failed++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
      tests_run++;
      if (c_out !== 1'b0) begin tests_failed++; $display("FAIL reset_c_out: got %b expected 0", c_out); end
      tests_run++;
      if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_wide: got in_ready=%b out_valid=%b expected 1 0", w_in_ready, w_out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int n;
      start_op(32'h0000_0001, 32'h0000_0001, 1'b0);
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: got in_ready=%b expected 0", in_ready); end
      wait_done(n);
      tests_run++;
      if (n != 4) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 4", n); end
      tests_run++;
      if (sum !== 32'h0000_0002 || c_out !== 1'b0) begin
         tests_failed++; $display("FAIL basic_sum: got %h/%b expected 00000002/0", sum, c_out);
      end
      release_result();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL basic_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_carry_chain();
      int n;
      start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      wait_done(n);
      tests_run++;
      if (n != 4) begin tests_failed++; $display("FAIL chain_latency: got %0d expected 4", n); end
      tests_run++;
      if (sum !== 32'h0000_0000 || c_out !== 1'b1) begin
         tests_failed++; $display("FAIL chain_sum: got %h/%b expected 00000000/1", sum, c_out);
      end
      release_result();
   endtask

   task automatic test_chunk_boundary();
      int n;
      start_op(32'h00FF_00FF, 32'h0001_0001, 1'b0);
      wait_done(n);
      tests_run++;
      if (sum !== 32'h0100_0100 || c_out !== 1'b0) begin
         tests_failed++; $display("FAIL boundary_sum: got %h/%b expected 01000100/0", sum, c_out);
      end
      release_result();
   endtask

   // Operand changes, in_valid and out_ready during RUN must not disturb the result.
   task automatic test_ignore_inputs();
      int n;
      start_op(32'h8000_0000, 32'h8000_0001, 1'b1);
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c_in = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      n = 2;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      tests_run++;
      if (n != 4) begin tests_failed++; $display("FAIL ignore_latency: got %0d expected 4", n); end
      tests_run++;
      if (sum !== 32'h0000_0002 || c_out !== 1'b1) begin
         tests_failed++; $display("FAIL ignore_sum: got %h/%b expected 00000002/1", sum, c_out);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int n;
      start_op(32'hF000_0000, 32'h2000_0000, 1'b0);
      wait_done(n);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         a = a ^ 32'h5A5A_5A5A;
         b = b + 32'h1;
         @(posedge clk); #1;
         tests_run++;
         if (sum !== 32'h1000_0000 || c_out !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_%0d: got sum=%h c_out=%b out_valid=%b in_ready=%b expected 10000000 1 1 0",
                     i, sum, c_out, out_valid, in_ready);
         end
      end
      in_valid = 1'b0;
      release_result();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL hold_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || sum !== 32'h0 || c_out !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrun_reset: got out_valid=%b sum=%h c_out=%b in_ready=%b expected 0 00000000 0 1",
                  out_valid, sum, c_out, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_op(32'd5, 32'd7, 1'b0);
      wait_done(n);
      tests_run++;
      if (n != 4) begin tests_failed++; $display("FAIL post_reset_latency: got %0d expected 4", n); end
      tests_run++;
      if (sum !== 32'd12 || c_out !== 1'b0) begin
         tests_failed++; $display("FAIL post_reset_sum: got %h/%b expected 0000000c/0", sum, c_out);
      end
      release_result();
   endtask

   task automatic test_single_chunk();
      int n;
      @(negedge clk);
      w_a = 32'h8000_0000; w_b = 32'h8000_0000; w_c_in = 1'b0; w_in_valid = 1'b1;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      n = 0;
      while (!w_out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      tests_run++;
      if (n != 1) begin tests_failed++; $display("FAIL wide_latency: got %0d expected 1", n); end
      tests_run++;
      if (w_sum !== 32'h0 || w_c_out !== 1'b1) begin
         tests_failed++; $display("FAIL wide_sum: got %h/%b expected 00000000/1", w_sum, w_c_out);
      end
      @(negedge clk);
      w_out_ready = 1'b1;
      @(posedge clk); #1;
      w_out_ready = 1'b0;
      tests_run++;
      if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL wide_release: got out_valid=%b in_ready=%b expected 0 1", w_out_valid, w_in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_chain();
      test_chunk_boundary();
      test_ignore_inputs();
      test_backpressure();
      test_reset_mid_run();
      test_single_chunk();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
